// File: rtl/ram_tile_dma.sv
// 2-D tile copy engine: reads 32-bit words from a strided source region and
// writes them to a strided destination region of the same single-port RAM.
module ram_tile_dma #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [31:0]      SRC_ADDR,
   input  logic [31:0]      DST_ADDR,
   input  logic [CNT_W-1:0] ROWS,
   input  logic [CNT_W-1:0] COLS,
   input  logic [31:0]      SRC_STRIDE,
   input  logic [31:0]      DST_STRIDE,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [31:0]      MEM_A,
   output logic [31:0]      MEM_D,
   input  logic [31:0]      MEM_Q,
   output logic             MEM_WE
);

   typedef enum logic [2:0] {IDLE, RD, WR, FIN, FAULT} state_t;

   state_t           state;
   logic [CNT_W-1:0] rows_q, cols_q, row, col;
   logic [31:0]      src_stride_q, dst_stride_q;
   logic [31:0]      src_row, dst_row, src, dst;
   logic [31:0]      data_reg;

   logic misaligned;
   assign misaligned = |{SRC_ADDR[1:0], DST_ADDR[1:0], SRC_STRIDE[1:0], DST_STRIDE[1:0]};

   // Bus and status are pure decodes of the state register, so the bus is
   // parked at zero whenever no word is being moved.
   assign BUSY   = (state == RD) || (state == WR);
   assign DONE   = (state == FIN);
   assign ERR    = (state == FAULT);
   assign MEM_WE = (state == WR);
   assign MEM_A  = (state == RD) ? src : (state == WR) ? dst : 32'h0;
   assign MEM_D  = (state == WR) ? data_reg : 32'h0;

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order inside the block.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         rows_q       <= '0;
         cols_q       <= '0;
         row          <= '0;
         col          <= '0;
         src_stride_q <= '0;
         dst_stride_q <= '0;
         src_row      <= '0;
         dst_row      <= '0;
         src          <= '0;
         dst          <= '0;
         data_reg     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  rows_q       <= ROWS;
                  cols_q       <= COLS;
                  src_stride_q <= SRC_STRIDE;
                  dst_stride_q <= DST_STRIDE;
                  row          <= '0;
                  col          <= '0;
                  src_row      <= SRC_ADDR;
                  src          <= SRC_ADDR;
                  dst_row      <= DST_ADDR;
                  dst          <= DST_ADDR;
                  if (misaligned)
                     state <= FAULT;
                  else if ((ROWS == '0) || (COLS == '0))
                     state <= FIN;
                  else
                     state <= RD;
               end
            end
            RD: begin
               data_reg <= MEM_Q;
               state    <= WR;
            end
            WR: begin
               if (col < cols_q - CNT_W'(1)) begin
                  col   <= col + CNT_W'(1);
                  src   <= src + 32'd4;
                  dst   <= dst + 32'd4;
                  state <= RD;
               end else if (row < rows_q - CNT_W'(1)) begin
                  // Next row restarts from the row base, not from the last word.
                  row     <= row + CNT_W'(1);
                  col     <= '0;
                  src_row <= src_row + src_stride_q;
                  dst_row <= dst_row + dst_stride_q;
                  src     <= src_row + src_stride_q;
                  dst     <= dst_row + dst_stride_q;
                  state   <= RD;
               end else begin
                  state <= FIN;
               end
            end
            FIN:     state <= IDLE;
            FAULT:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_tile_dma.sv
// Directed bench for ram_tile_dma with a behavioural single-port RAM model
// and a negedge monitor that counts write, busy, done and error cycles.
module tb_ram_tile_dma;

   localparam int CNT_W = 16;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             START = 1'b0;
   logic [31:0]      SRC_ADDR = '0, DST_ADDR = '0, SRC_STRIDE = '0, DST_STRIDE = '0;
   logic [CNT_W-1:0] ROWS = '0, COLS = '0;
   logic             BUSY, DONE, ERR, MEM_WE;
   logic [31:0]      MEM_A, MEM_D, MEM_Q;

   logic [31:0] mem [1024];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int start_edge = 0;
   bit mon_on = 1'b0;
   int we_cnt, busy_cnt, busy_first, busy_last, done_cnt, done_cyc, err_cnt, err_cyc;

   ram_tile_dma #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .START(START),
      .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .ROWS(ROWS), .COLS(COLS),
      .SRC_STRIDE(SRC_STRIDE), .DST_STRIDE(DST_STRIDE),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
      .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_Q(MEM_Q), .MEM_WE(MEM_WE)
   );

   always #5 CLK = ~CLK;

   assign MEM_Q = mem[MEM_A[11:2]];

   always @(posedge CLK) begin
      cyc = cyc + 1;
      if (MEM_WE) mem[MEM_A[11:2]] = MEM_D;
   end

   // Cycle k is the period that ends at edge k, START being sampled at edge 0.
   always @(negedge CLK) begin
      if (mon_on) begin
         int idx;
         idx = cyc - start_edge + 1;
         if (MEM_WE) we_cnt = we_cnt + 1;
         if (BUSY) begin
            busy_cnt = busy_cnt + 1;
            if (busy_first == 0) busy_first = idx;
            busy_last = idx;
         end
         if (DONE) begin done_cnt = done_cnt + 1; done_cyc = idx; end
         if (ERR)  begin err_cnt  = err_cnt + 1;  err_cyc  = idx; end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem[a[11:2]];
   endfunction

   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      mem[a[11:2]] = v;
   endtask

   task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                             input int r, input int c,
                             input logic [31:0] ss, input logic [31:0] ds);
      @(negedge CLK);
      SRC_ADDR = s; DST_ADDR = d; ROWS = CNT_W'(r); COLS = CNT_W'(c);
      SRC_STRIDE = ss; DST_STRIDE = ds; START = 1'b1;
      @(posedge CLK);
      #1;
      start_edge = cyc;
      we_cnt = 0; busy_cnt = 0; busy_first = 0; busy_last = 0;
      done_cnt = 0; done_cyc = 0; err_cnt = 0; err_cyc = 0;
      mon_on = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int n;
      n = 0;
      while ((done_cnt + err_cnt) == 0 && n < budget) begin
         @(negedge CLK);
         #1;
         n = n + 1;
      end
      if ((done_cnt + err_cnt) == 0) check("timeout", 32'd1, 32'd0);
      repeat (3) @(negedge CLK);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

      // Reset state
      repeat (3) @(negedge CLK);
      #1;
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
      check("rst_mem_a", MEM_A, 32'd0);
      check("rst_mem_d", MEM_D, 32'd0);
      check("rst_mem_we", 32'(MEM_WE), 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      // 1x4 copy
      for (int i = 0; i < 4; i++) wr(32'h100 + 32'(4 * i), 32'(i + 1));
      start_xfer(32'h100, 32'h200, 1, 4, 32'h0, 32'h0);
      wait_end(40);
      for (int i = 0; i < 4; i++) check("copy1x4_word", rd(32'h200 + 32'(4 * i)), 32'(i + 1));
      check("copy1x4_we_cycles", 32'(we_cnt), 32'd4);
      check("copy1x4_done_cycle", 32'(done_cyc), 32'd9);
      check("copy1x4_done_count", 32'(done_cnt), 32'd1);
      check("copy1x4_busy_first", 32'(busy_first), 32'd1);
      check("copy1x4_busy_last", 32'(busy_last), 32'd8);
      check("copy1x4_busy_cycles", 32'(busy_cnt), 32'd8);
      check("copy1x4_idle_mem_a", MEM_A, 32'd0);
      check("copy1x4_idle_mem_d", MEM_D, 32'd0);

      // 2x3 gather with source and destination strides
      for (int i = 0; i < 3; i++) begin
         wr(32'h400 + 32'(4 * i), 32'(10 + i));
         wr(32'h440 + 32'(4 * i), 32'(20 + i));
      end
      start_xfer(32'h400, 32'h800, 2, 3, 32'h40, 32'h0C);
      wait_end(60);
      check("gather_w0", rd(32'h800), 32'd10);
      check("gather_w1", rd(32'h804), 32'd11);
      check("gather_w2", rd(32'h808), 32'd12);
      check("gather_w3", rd(32'h80C), 32'd20);
      check("gather_w4", rd(32'h810), 32'd21);
      check("gather_w5", rd(32'h814), 32'd22);
      for (int a = 32'h40C; a <= 32'h43C; a += 4)
         check("gather_src_gap", rd(32'(a)), 32'hDEAD_0000 | 32'(a >> 2));
      check("gather_below_dst", rd(32'h7FC), 32'hDEAD_01FF);
      check("gather_above_dst", rd(32'h818), 32'hDEAD_0206);
      check("gather_we_cycles", 32'(we_cnt), 32'd6);
      check("gather_done_cycle", 32'(done_cyc), 32'd13);

      // Zero-size request
      start_xfer(32'h100, 32'h900, 0, 5, 32'h0, 32'h0);
      wait_end(20);
      check("zero_done_cycle", 32'(done_cyc), 32'd1);
      check("zero_we_cycles", 32'(we_cnt), 32'd0);
      check("zero_err_count", 32'(err_cnt), 32'd0);
      check("zero_busy_cycles", 32'(busy_cnt), 32'd0);

      // Misaligned source, then an aligned request
      start_xfer(32'h102, 32'h300, 1, 4, 32'h0, 32'h0);
      wait_end(20);
      check("misalign_err_cycle", 32'(err_cyc), 32'd1);
      check("misalign_err_count", 32'(err_cnt), 32'd1);
      check("misalign_done_count", 32'(done_cnt), 32'd0);
      check("misalign_we_cycles", 32'(we_cnt), 32'd0);
      check("misalign_dst_untouched", rd(32'h300), 32'hDEAD_00C0);
      start_xfer(32'h100, 32'h300, 1, 4, 32'h0, 32'h0);
      wait_end(40);
      check("after_err_done_cycle", 32'(done_cyc), 32'd9);
      check("after_err_word3", rd(32'h30C), 32'd4);

      // Second START with a different destination during a transfer
      start_xfer(32'h100, 32'h500, 1, 4, 32'h0, 32'h0);
      repeat (2) @(negedge CLK);
      DST_ADDR = 32'h600; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_end(40);
      for (int i = 0; i < 4; i++) check("ignore_start_dst", rd(32'h500 + 32'(4 * i)), 32'(i + 1));
      check("ignore_start_other0", rd(32'h600), 32'hDEAD_0180);
      check("ignore_start_other3", rd(32'h60C), 32'hDEAD_0183);
      check("ignore_start_done_count", 32'(done_cnt), 32'd1);
      check("ignore_start_we_cycles", 32'(we_cnt), 32'd4);

      // Reset on the edge that ends the third WR (cycle 6)
      start_xfer(32'h100, 32'hA00, 1, 4, 32'h0, 32'h0);
      repeat (5) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      #1;
      check("midrst_mem_we", 32'(MEM_WE), 32'd0);
      check("midrst_busy", 32'(BUSY), 32'd0);
      RST = 1'b0;
      repeat (20) @(negedge CLK);
      #1;
      check("midrst_w0", rd(32'hA00), 32'd1);
      check("midrst_w1", rd(32'hA04), 32'd2);
      check("midrst_w2", rd(32'hA08), 32'd3);
      check("midrst_w3_untouched", rd(32'hA0C), 32'hDEAD_0283);
      check("midrst_we_cycles", 32'(we_cnt), 32'd3);
      check("midrst_done_count", 32'(done_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_tile_dma.md
Name: ram_tile_dma

Overview:
- Bus initiator for the single-port data `ram`. Drives its A/D/WE and reads its combinational Q.
- Copies a 2-D tile of 32-bit words from a source region to a destination region in the same RAM. Example use: gathering one matmul tile into a packed buffer, or scattering results back to `OUTPUT_ADDR`.
- Started by the CPU-side controller with a START/BUSY/DONE handshake.

Parameters:
- CNT_W, 16, width of the ROWS and COLS counts.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  transfer request; sampled only in IDLE.
- SRC_ADDR  input  32  byte address of source tile element (0,0).
- DST_ADDR  input  32  byte address of destination tile element (0,0).
- ROWS  input  CNT_W  tile rows.
- COLS  input  CNT_W  words per row.
- SRC_STRIDE  input  32  source row pitch, in bytes.
- DST_STRIDE  input  32  destination row pitch, in bytes.
- BUSY  output  1  high while a transfer is in RD or WR.
- DONE  output  1  one-cycle pulse when a transfer completes.
- ERR  output  1  one-cycle pulse when a request is rejected for misalignment.
- MEM_A  output  32  RAM byte address.
- MEM_D  output  32  RAM write data.
- MEM_Q  input  32  RAM read data; valid in the same cycle as MEM_A.
- MEM_WE  output  1  RAM write enable.

Behaviour:
- States: IDLE, RD, WR, FIN, FAULT.
- Reset:
  - RST=1 at an edge forces IDLE.
  - Clears the word counters and the data register.
  - Outputs after reset: BUSY=0, DONE=0, ERR=0, MEM_A=0, MEM_D=0, MEM_WE=0.
- Output decode: MEM_WE, BUSY, DONE and ERR decode from state only, so MEM_WE is low in the cycle after a reset edge.
- IDLE:
  - START=1 latches all request inputs.
  - Any of SRC_ADDR, DST_ADDR, SRC_STRIDE or DST_STRIDE with bits [1:0] nonzero -> FAULT.
  - Else ROWS=0 or COLS=0 -> FIN with no RAM access.
  - Else -> RD with row=0, col=0, src_row=src=SRC_ADDR, dst_row=dst=DST_ADDR.
- RD:
  - MEM_A=src, MEM_WE=0.
  - At the edge: data_reg<=MEM_Q, then go to WR.
- WR:
  - MEM_A=dst, MEM_D=data_reg, MEM_WE=1.
  - At the edge the RAM commits the write, then the counters advance:
    - If col<COLS-1: col+1, src+=4, dst+=4, go to RD.
    - Else if row<ROWS-1: row+1, col=0, src_row+=SRC_STRIDE, dst_row+=DST_STRIDE, src=new src_row, dst=new dst_row, go to RD.
    - Else go to FIN.
- FIN: DONE=1 for one cycle, then IDLE.
- FAULT: ERR=1 for one cycle, then IDLE. No RAM access occurs.
- Throughput: 2 cycles per word.
  - With START seen at edge 0, DONE is high during cycle 2*ROWS*COLS+1.
  - MEM_WE is high for exactly ROWS*COLS cycles.
- Idle bus: outside RD and WR, MEM_A=0, MEM_D=0, MEM_WE=0.
- Request latching: START while not IDLE is ignored. Input changes during a transfer have no effect.
- Arithmetic: all address arithmetic is unsigned 32-bit and wraps modulo 2^32. Counters are CNT_W bits wide.
- Copy order is row-major ascending. There is no overlap detection.
  - A destination that overlaps the source at a higher address can corrupt unread source data; software must avoid this.
  - DST_ADDR==SRC_ADDR with equal strides is a legal no-op copy.
- Reset mid-transfer:
  - Writes already committed remain.
  - No further MEM_WE is issued, and DONE is not pulsed.

Test Plan:
- 1x4 copy: RAM words 0x100..0x10C=1,2,3,4; SRC=0x100, DST=0x200, ROWS=1, COLS=4, strides 0 -> words 0x200..0x20C=1,2,3,4; MEM_WE high exactly 4 cycles; DONE in cycle 9; BUSY high in cycles 1-8.
- 2x3 gather: source rows at 0x400 and 0x440 (SRC_STRIDE=0x40) holding 10,11,12 / 20,21,22; DST=0x800, DST_STRIDE=0x0C -> 0x800..0x814=10,11,12,20,21,22; addresses 0x40C..0x43C and words outside 0x800..0x814 unchanged.
- Zero size: ROWS=0, COLS=5 -> DONE in cycle 1, MEM_WE never high, ERR=0.
- Misalignment: SRC=0x102 -> ERR in cycle 1, DONE never, MEM_WE never; the next aligned request completes normally.
- START ignored during transfer: second START with different DST pulsed in cycle 3 of a 1x4 copy -> only the original destination is written; one DONE.
- Reset mid-transfer: RST asserted at the edge ending the third WR of a 1x4 copy -> first 3 destination words written, 4th unchanged; MEM_WE low and BUSY low from the next cycle; DONE never pulses.
